// File: rtl/aes_inv_cipher_seq_pkg.sv
// Shared AES-128 inverse-cipher constants, FSM encoding and GF(2^8) helpers.
// Byte i of a 128-bit block sits at [127-8*i -: 8], column-major (i = 4*c + r).
package aes_inv_cipher_seq_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;
  localparam int AES_RK_W  = 1408;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
      o[119-32*c -: 8] = gmul9(a0) ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
      o[111-32*c -: 8] = gmul13(a0) ^ gmul9(a1) ^ gmul14(a2) ^ gmul11(a3);
      o[103-32*c -: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2) ^ gmul14(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_seq_sbox.sv
// Combinational AES inverse S-box lookup, one byte.
// Table rows are indexed by the high nibble of the input byte.
module aes_inv_cipher_seq_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign byte_o = INV_SBOX[byte_i];

endmodule

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES-128 inverse cipher, one inverse round per clock.
// Round keys are read live from the bus and must stay stable while busy.
module aes_inv_cipher_seq
  import aes_inv_cipher_seq_pkg::*;
#(
  parameter int NR   = AES_NR,
  parameter int RK_W = 128 * (NR + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    ciphertext,
  input  logic [RK_W-1:0] round_keys,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    plaintext,
  output logic            busy
);

  aes_fsm_e     fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] state_q, state_d;
  logic [127:0] pt_q, pt_d;

  logic [127:0] rk_sel;
  logic [127:0] isr;
  logic [127:0] sb;
  logic [127:0] ark;
  logic [127:0] imc;

  // Select round key rnd_q; key r lives at the top end for r = 0.
  always_comb begin
    rk_sel = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rnd_q == 4'(i)) rk_sel = round_keys[RK_W-1-128*i -: 128];
    end
  end

  assign isr = inv_shift_rows(state_q);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_cipher_seq_sbox u_sbox (
      .byte_i (isr[127-8*g -: 8]),
      .byte_o (sb[127-8*g -: 8])
    );
  end

  assign ark = sb ^ rk_sel;
  assign imc = inv_mix_columns(ark);

  // Next-state and handshake outputs.
  always_comb begin
    fsm_d     = fsm_q;
    rnd_d     = rnd_q;
    state_d   = state_q;
    pt_d      = pt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ciphertext ^ round_keys[127:0];
          rnd_d   = 4'(NR - 1);
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        busy = 1'b1;
        if (rnd_q == 4'd0) begin
          pt_d  = ark;
          fsm_d = ST_DONE;
        end else begin
          state_d = imc;
          rnd_d   = rnd_q - 4'd1;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      rnd_q   <= 4'd0;
      state_q <= '0;
      pt_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      pt_q    <= pt_d;
    end
  end

  assign plaintext = pt_q;

endmodule
